// File: rtl/cp0_exc_sched_pkg.sv
// Shared definitions for the CP0 exception scheduler: event codes, CP0 register
// indices, Status/Cause bit positions and the scheduler state type.
package cp0_exc_sched_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    // Codes above the architectural range mark "nothing" and eret.
    localparam logic [4:0] EXC_ERET = 5'd30;
    localparam logic [4:0] EXC_NONE = 5'd31;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int CAUSE_IP_LO  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MASK = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [4:0]  exccode;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic        in_delay;
    } exc_event_t;

endpackage

// File: rtl/cp0_exc_sched_if.sv
// Bundle between the commit stage / CP0 register file and the exception scheduler.
interface cp0_exc_sched_if;
    logic [5:0]  ext_int;
    logic        s0_valid;
    logic        s1_valid;
    logic [4:0]  s0_exccode;
    logic [4:0]  s1_exccode;
    logic [31:0] s0_pc;
    logic [31:0] s1_pc;
    logic [31:0] s0_badaddr;
    logic [31:0] s1_badaddr;
    logic        s0_in_delay;
    logic        s1_in_delay;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  exccode_o;
    logic [31:0] pc_o;
    logic [31:0] badaddr_o;
    logic        in_delay_o;
    logic        s1_kill_o;
    logic [5:0]  hw_ip_o;
    logic [31:0] count_o;

    modport slave (
        input  ext_int, s0_valid, s1_valid, s0_exccode, s1_exccode, s0_pc, s1_pc,
               s0_badaddr, s1_badaddr, s0_in_delay, s1_in_delay, status_i, cause_i,
               cp0_we, cp0_waddr, cp0_wdata,
        output exccode_o, pc_o, badaddr_o, in_delay_o, s1_kill_o, hw_ip_o, count_o
    );

    modport master (
        output ext_int, s0_valid, s1_valid, s0_exccode, s1_exccode, s0_pc, s1_pc,
               s0_badaddr, s1_badaddr, s0_in_delay, s1_in_delay, status_i, cause_i,
               cp0_we, cp0_waddr, cp0_wdata,
        input  exccode_o, pc_o, badaddr_o, in_delay_o, s1_kill_o, hw_ip_o, count_o
    );
endinterface

// File: rtl/cp0_exc_sched_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, timer_ip latches on a
// Count==Compare increment and clears only on a Compare write.
module cp0_timer
    import cp0_exc_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic        timer_ip_o
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tog_q, tog_d, ip_q, ip_d;
    logic        count_wr, compare_wr, match;

    always_comb begin
        count_wr   = we_i && (waddr_i == CP0_REG_COUNT);
        compare_wr = we_i && (waddr_i == CP0_REG_COMPARE);
        count_d    = count_q;
        compare_d  = compare_q;
        tog_d      = ~tog_q;
        ip_d       = ip_q;
        match      = 1'b0;
        if (count_wr) begin
            count_d = wdata_i;
            tog_d   = 1'b0;
        end else if (tog_q) begin
            count_d = count_q + 32'd1;
            match   = (count_d == compare_q);
        end
        // A Compare write in the match cycle wins over the match.
        if (compare_wr) begin
            compare_d = wdata_i;
            ip_d      = 1'b0;
        end else if (match) begin
            ip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tog_q     <= 1'b0;
            ip_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tog_q     <= tog_d;
            ip_q      <= ip_d;
        end
    end

    assign count_o    = count_q;
    assign timer_ip_o = ip_q;
endmodule

// File: rtl/cp0_exc_sched.sv
// CP0 exception/interrupt scheduler: picks one commit event per cycle in architectural
// order, then masks wrong-path events during the flush. Timer built under CP0_TIMER_EN.
//
// state | meaning
// IDLE  | selecting events from the commit slots / pending interrupt
// MASK  | flush in progress, every event suppressed until cnt_q reaches 0
module cp0_exc_sched
    import cp0_exc_sched_pkg::*;
#(
    parameter int FLUSH_CYCLES    = 2,
    parameter int INT_SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    cp0_exc_sched_if.slave bus
);
    logic [INT_SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]   hw_ip;
    logic [7:0]   ip_all;
    logic         int_req;
    logic         timer_ip;
    logic [31:0]  count;
    sched_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    exc_event_t   ev;
    logic         ev_valid;
    logic         s1_kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.ext_int;
            for (int i = 1; i < INT_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .we_i       (bus.cp0_we),
        .waddr_i    (bus.cp0_waddr),
        .wdata_i    (bus.cp0_wdata),
        .count_o    (count),
        .timer_ip_o (timer_ip)
    );
`else
    assign count    = '0;
    assign timer_ip = 1'b0;
`endif

    assign hw_ip   = {sync_q[INT_SYNC_STAGES-1][5] | timer_ip, sync_q[INT_SYNC_STAGES-1][4:0]};
    assign ip_all  = {hw_ip, bus.cause_i[CAUSE_IP_LO +: 2]};
    assign int_req = bus.status_i[STATUS_IE] & ~bus.status_i[STATUS_EXL]
                   & |(bus.status_i[STATUS_IM_LO +: 8] & ip_all);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (ev_valid) begin
                state_d = ST_MASK;
                cnt_d   = 4'(FLUSH_CYCLES - 1);
            end
            ST_MASK: if (cnt_q == 4'd0) state_d = ST_IDLE;
                     else               cnt_d   = cnt_q - 4'd1;
            default: state_d = ST_IDLE;
        endcase
    end

    // Interrupts are only ever taken on slot 0; a pending one waits for s0_valid.
    always_comb begin
        ev      = '{exccode: EXC_NONE, pc: '0, badaddr: '0, in_delay: 1'b0};
        s1_kill = 1'b0;
        if (state_q == ST_IDLE) begin
            if (int_req && bus.s0_valid) begin
                ev      = '{EXC_INT, bus.s0_pc, bus.s0_badaddr, bus.s0_in_delay};
                s1_kill = 1'b1;
            end else if (bus.s0_valid && bus.s0_exccode != EXC_NONE) begin
                ev      = '{bus.s0_exccode, bus.s0_pc, bus.s0_badaddr, bus.s0_in_delay};
                s1_kill = 1'b1;
            end else if (bus.s1_valid && bus.s1_exccode != EXC_NONE) begin
                ev      = '{bus.s1_exccode, bus.s1_pc, bus.s1_badaddr, bus.s1_in_delay};
            end
        end
    end

    assign ev_valid       = (ev.exccode != EXC_NONE);
    assign bus.exccode_o  = ev.exccode;
    assign bus.pc_o       = ev.pc;
    assign bus.badaddr_o  = ev.badaddr;
    assign bus.in_delay_o = ev.in_delay;
    assign bus.s1_kill_o  = s1_kill;
    assign bus.hw_ip_o    = hw_ip;
    assign bus.count_o    = count;
endmodule

// File: tb/tb_cp0_exc_sched.sv
// Bench for cp0_exc_sched: directed vectors, a cycle-level reference model of the
// scheduling rules, and literal expectations at the key points.
module tb_cp0_exc_sched;
    import cp0_exc_sched_pkg::*;

    localparam int FLUSH = 2;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cp0_exc_sched_if bus ();

    cp0_exc_sched #(.FLUSH_CYCLES(FLUSH), .INT_SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model state: cycle index, end of the flush window, input history for
    // the synchroniser, and the timer expressed as a load value plus elapsed cycles.
    int          cyc, block_until, base_cyc;
    logic [5:0]  hist[$];
    logic        tip, exp_issue;
    logic [31:0] base, cmp;

    logic [5:0]  e_hw;
    logic [7:0]  e_ip;
    logic        e_ireq, e_dl, e_kill;
    logic [4:0]  e_code;
    logic [31:0] e_pc, e_ba, e_cnt;

    function automatic logic [31:0] model_count(input int c);
`ifdef CP0_TIMER_EN
        return base + 32'((c - base_cyc) / 2);
`else
        return 32'd0 + 32'(c - c);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; block_until = -1; base_cyc = 0;
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(6'd0);
            tip = 1'b0; base = '0; cmp = '0; exp_issue = 1'b0;
        end else begin
`ifdef CP0_TIMER_EN
            begin
                logic cw, mw, inc;
                logic [31:0] now_c;
                cw = bus.cp0_we && bus.cp0_waddr == CP0_REG_COUNT;
                mw = bus.cp0_we && bus.cp0_waddr == CP0_REG_COMPARE;
                now_c = model_count(cyc);
                inc = ((cyc + 1 - base_cyc) / 2) != ((cyc - base_cyc) / 2);
                if (!cw && inc && !mw && (now_c + 32'd1) == cmp) tip = 1'b1;
                if (mw) begin cmp = bus.cp0_wdata; tip = 1'b0; end
                if (cw) begin base = bus.cp0_wdata; base_cyc = cyc + 1; end
            end
`endif
            if (exp_issue) block_until = cyc + FLUSH;
            hist.push_front(bus.ext_int);
            void'(hist.pop_back());
            cyc++;
        end
    end

    always @(negedge clk) begin
        e_hw   = rst ? 6'd0 : (hist[SYNC-1] | {tip, 5'd0});
        e_ip   = {e_hw, bus.cause_i[9:8]};
        e_ireq = bus.status_i[0] & ~bus.status_i[1] & |(bus.status_i[15:8] & e_ip);
        e_code = EXC_NONE; e_pc = '0; e_ba = '0; e_dl = 1'b0; e_kill = 1'b0;
        e_cnt  = rst ? 32'd0 : model_count(cyc);
        if (!rst && cyc > block_until) begin
            if (e_ireq && bus.s0_valid) begin
                e_code = EXC_INT; e_pc = bus.s0_pc; e_ba = bus.s0_badaddr;
                e_dl = bus.s0_in_delay; e_kill = 1'b1;
            end else if (bus.s0_valid && bus.s0_exccode != EXC_NONE) begin
                e_code = bus.s0_exccode; e_pc = bus.s0_pc; e_ba = bus.s0_badaddr;
                e_dl = bus.s0_in_delay; e_kill = 1'b1;
            end else if (bus.s1_valid && bus.s1_exccode != EXC_NONE) begin
                e_code = bus.s1_exccode; e_pc = bus.s1_pc; e_ba = bus.s1_badaddr;
                e_dl = bus.s1_in_delay;
            end
        end
        check("mdl_exccode",  bus.exccode_o,  e_code);
        check("mdl_pc",       bus.pc_o,       e_pc);
        check("mdl_badaddr",  bus.badaddr_o,  e_ba);
        check("mdl_in_delay", bus.in_delay_o, e_dl);
        check("mdl_s1_kill",  bus.s1_kill_o,  e_kill);
        check("mdl_hw_ip",    bus.hw_ip_o,    e_hw);
        check("mdl_count",    bus.count_o,    e_cnt);
        exp_issue = (e_code != EXC_NONE);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.s0_valid = 0; bus.s0_exccode = EXC_NONE; bus.s0_pc = '0; bus.s0_badaddr = '0; bus.s0_in_delay = 0;
        bus.s1_valid = 0; bus.s1_exccode = EXC_NONE; bus.s1_pc = '0; bus.s1_badaddr = '0; bus.s1_in_delay = 0;
        bus.cp0_we = 0; bus.cp0_waddr = '0; bus.cp0_wdata = '0;
    endtask

    task automatic slot0(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] ba, input logic dl);
        bus.s0_valid = 1; bus.s0_exccode = c; bus.s0_pc = pc; bus.s0_badaddr = ba; bus.s0_in_delay = dl;
    endtask

    task automatic slot1(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] ba, input logic dl);
        bus.s1_valid = 1; bus.s1_exccode = c; bus.s1_pc = pc; bus.s1_badaddr = ba; bus.s1_in_delay = dl;
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.ext_int = '0; bus.status_i = '0; bus.cause_i = '0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exccode", bus.exccode_o, EXC_NONE);
        check("rst_pc",      bus.pc_o, 32'd0);
        check("rst_hw_ip",   bus.hw_ip_o, 32'd0);
        check("rst_count",   bus.count_o, 32'd0);
        tick();
        rst = 1'b0;

        // slot 1 fault, then two masked cycles despite new slot-1 faults
        slot1(EXC_ADEL, 32'hBFC0_0104, 32'hBFC0_0105, 1'b0);
        @(negedge clk);
        check("s1_code", bus.exccode_o, EXC_ADEL);
        check("s1_pc",   bus.pc_o, 32'hBFC0_0104);
        check("s1_kill", bus.s1_kill_o, 32'd0);
        tick();
        slot1(EXC_ADES, 32'h0000_0200, 32'h0000_0203, 1'b1);
        @(negedge clk); check("mask_1", bus.exccode_o, EXC_NONE);
        tick();
        @(negedge clk); check("mask_2", bus.exccode_o, EXC_NONE);
        tick();
        @(negedge clk);
        check("reissue_code", bus.exccode_o, EXC_ADES);
        check("reissue_dly",  bus.in_delay_o, 32'd1);
        tick(); set_idle(); repeat (3) tick();

        // both slots faulting: older slot wins and kills slot 1
        slot0(EXC_SYS, 32'h0000_0100, 32'h0, 1'b0);
        slot1(EXC_ADES, 32'h0000_0104, 32'h0000_0108, 1'b1);
        @(negedge clk);
        check("both_code", bus.exccode_o, EXC_SYS);
        check("both_pc",   bus.pc_o, 32'h0000_0100);
        check("both_kill", bus.s1_kill_o, 32'd1);
        tick(); set_idle(); repeat (3) tick();

        // eret takes the same path and masks the following cycle
        slot0(EXC_ERET, 32'h0000_0300, 32'h0, 1'b0);
        @(negedge clk); check("eret_code", bus.exccode_o, EXC_ERET);
        tick(); set_idle();
        slot1(EXC_ADEL, 32'h0000_0304, 32'h0000_0305, 1'b0);
        @(negedge clk); check("eret_mask", bus.exccode_o, EXC_NONE);
        tick(); set_idle(); repeat (3) tick();

        // hardware interrupt through the synchroniser
        bus.status_i = 32'h0000_0401;
        bus.ext_int  = 6'b000001;
        @(negedge clk); check("sync_0", bus.hw_ip_o, 32'd0);
        tick();
        @(negedge clk); check("sync_1", bus.hw_ip_o, 32'd0);
        tick();
        @(negedge clk);
        check("sync_2",   bus.hw_ip_o, 32'd1);
        check("int_wait", bus.exccode_o, EXC_NONE);
        tick();
        slot0(EXC_NONE, 32'h0000_2000, 32'h0, 1'b1);
        slot1(EXC_ADEL, 32'h0000_2004, 32'h0000_2005, 1'b0);
        @(negedge clk);
        check("int_code", bus.exccode_o, EXC_INT);
        check("int_pc",   bus.pc_o, 32'h0000_2000);
        check("int_kill", bus.s1_kill_o, 32'd1);
        tick(); set_idle(); repeat (3) tick();
        bus.status_i = 32'h0000_0403;
        slot0(EXC_NONE, 32'h0000_2008, 32'h0, 1'b0);
        @(negedge clk); check("exl_block", bus.exccode_o, EXC_NONE);
        tick(); set_idle();

        // software interrupt via Cause IP0
        bus.ext_int = '0; bus.status_i = 32'h0000_0101; bus.cause_i = 32'h0000_0100;
        repeat (3) tick();
        slot0(EXC_NONE, 32'h0000_3000, 32'h0, 1'b0);
        @(negedge clk);
        check("swint_code", bus.exccode_o, EXC_INT);
        check("swint_pc",   bus.pc_o, 32'h0000_3000);
        tick(); set_idle(); bus.cause_i = '0; bus.status_i = '0;
        bus.ext_int = 6'b100000;
        repeat (3) tick();
        @(negedge clk); check("hw5_ext", bus.hw_ip_o, 32'h20);
        bus.ext_int = '0;
        repeat (3) tick();

`ifdef CP0_TIMER_EN
        cp0_write(CP0_REG_COMPARE, 32'd4); tick();
        cp0_write(CP0_REG_COUNT, 32'd0);   tick();
        bus.cp0_we = 0;
        repeat (7) tick();
        @(negedge clk);
        check("tmr_cnt7", bus.count_o, 32'd3);
        check("tmr_ip7",  bus.hw_ip_o, 32'd0);
        tick();
        @(negedge clk);
        check("tmr_cnt8", bus.count_o, 32'd4);
        check("tmr_ip8",  bus.hw_ip_o, 32'h20);
        cp0_write(CP0_REG_COMPARE, 32'd4); tick();
        cp0_write(CP0_REG_COUNT, 32'd0);   tick();
        bus.cp0_we = 0;
        repeat (7) tick();
        cp0_write(CP0_REG_COMPARE, 32'd4); tick();
        bus.cp0_we = 0;
        @(negedge clk);
        check("tmr_race_cnt", bus.count_o, 32'd4);
        check("tmr_race_ip",  bus.hw_ip_o, 32'd0);
        cp0_write(CP0_REG_COUNT, 32'hFFFF_FFFF); tick();
        bus.cp0_we = 0;
        @(negedge clk); check("wrap_0", bus.count_o, 32'hFFFF_FFFF);
        tick();
        @(negedge clk); check("wrap_1", bus.count_o, 32'hFFFF_FFFF);
        tick();
        @(negedge clk); check("wrap_2", bus.count_o, 32'd0);
`else
        cp0_write(CP0_REG_COUNT, 32'h0000_1234); tick();
        cp0_write(CP0_REG_COMPARE, 32'd1);       tick();
        bus.cp0_we = 0;
        repeat (4) tick();
        @(negedge clk);
        check("notmr_count", bus.count_o, 32'd0);
        check("notmr_ip",    bus.hw_ip_o, 32'd0);
`endif
        tick();

        // reset in the middle of the flush window
        slot0(EXC_SYS, 32'h0000_0500, 32'h0000_0504, 1'b0);
        @(negedge clk); check("pre_rst_code", bus.exccode_o, EXC_SYS);
        tick(); set_idle();
        slot1(EXC_ADEL, 32'h0000_0508, 32'h0000_0509, 1'b0);
        @(negedge clk); check("pre_rst_mask", bus.exccode_o, EXC_NONE);
        tick();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_code",  bus.exccode_o, EXC_NONE);
        check("midrst_count", bus.count_o, 32'd0);
        check("midrst_kill",  bus.s1_kill_o, 32'd0);
        tick();
        rst = 1'b0;
        slot0(EXC_SYS, 32'h0000_0600, 32'h0000_0604, 1'b1);
        @(negedge clk);
        check("postrst_code", bus.exccode_o, EXC_SYS);
        check("postrst_pc",   bus.pc_o, 32'h0000_0600);
        tick(); set_idle(); repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
